// File: rtl/hyper_pkg.sv
// Shared HyperBus target definitions: FSM states, command/address field
// positions, and the configuration register default.
package hyper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_WDATA,
    ST_RDATA,
    ST_REGW
  } state_e;

  localparam int unsigned CA_BYTES  = 6;
  localparam int unsigned CA_RW_BIT = 47;
  localparam int unsigned CA_AS_BIT = 46;
  localparam int unsigned CA_ROW_HI = 44;
  localparam int unsigned CA_ROW_LO = 16;
  localparam int unsigned CA_COL_HI = 2;

  localparam logic [15:0] CR0_DEFAULT = 16'h8F1F;

  typedef struct packed {
    logic        is_read;
    logic        is_reg;
    logic [31:0] word_addr;
  } ca_dec_t;

  function automatic ca_dec_t ca_decode(input logic [47:0] ca);
    ca_dec_t d;
    d.is_read   = ca[CA_RW_BIT];
    d.is_reg    = ca[CA_AS_BIT];
    d.word_addr = {ca[CA_ROW_HI:CA_ROW_LO], ca[CA_COL_HI:0]};
    return d;
  endfunction

endpackage

// File: rtl/hyper_target_mem.sv
// Single-port 16-bit word array with per-byte write enables and
// registered read data.
module hyper_target_mem #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        be_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o
);

  logic [15:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/hyper_target.sv
// HyperBus memory target: oversamples the bus with clk, decodes CA,
// applies fixed 2x latency and serves a word array plus CR0.
module hyper_target
  import hyper_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned LATENCY  = 6,
  parameter logic [15:0] CR0_INIT = CR0_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dram_ck,
  input  logic       dram_cs_l,
  input  logic       dram_rst_l,
  input  logic [7:0] dram_dq_in,
  output logic [7:0] dram_dq_out,
  output logic       dram_dq_oe_l,
  input  logic       dram_rwds_in,
  output logic       dram_rwds_out,
  output logic       dram_rwds_oe_l,
  output logic       busy
);

  localparam logic [11:0] SYNC_IDLE = {1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
  localparam logic [7:0]  LAT_EDGES = 8'(2 * LATENCY);
  localparam logic [2:0]  CA_LAST   = 3'(CA_BYTES - 1);

  state_e            state_q;
  logic [11:0]       sync1_q, sync2_q;
  logic              ck_prev_q, cs_prev_q;
  logic [39:0]       ca_q;
  logic [2:0]        cnt_q;
  logic [7:0]        lat_q;
  logic              is_read_q, is_reg_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       cr0_q;
  logic [7:0]        dq_out_q;
  logic              dq_oe_l_q, rwds_out_q, rwds_oe_l_q;

  logic        ck_s, cs_s, rst_s, rwds_s;
  logic [7:0]  dq_s;
  logic        ck_edge, ck_rise, ck_fall;
  logic [47:0] ca_next;
  ca_dec_t     dec;
  logic [1:0]  mem_be;
  logic [15:0] mem_rdata, rd_word;

  assign {ck_s, cs_s, rst_s, rwds_s, dq_s} = sync2_q;
  assign ck_edge = ck_s ^ ck_prev_q;
  assign ck_rise = ck_edge & ck_s;
  assign ck_fall = ck_edge & ~ck_s;
  assign ca_next = {ca_q, dq_s};
  assign rd_word = is_reg_q ? cr0_q : mem_rdata;

  always_comb begin
    dec    = ca_decode(ca_next);
    mem_be = '0;
    if (state_q == ST_WDATA && !cs_s && rst_s && !rwds_s)
      mem_be = {ck_rise, ck_fall};
  end

  hyper_target_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk_i   (clk),
    .addr_i  (addr_q),
    .be_i    (mem_be),
    .wdata_i ({dq_s, dq_s}),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sync1_q     <= SYNC_IDLE;
      sync2_q     <= SYNC_IDLE;
      ck_prev_q   <= 1'b0;
      cs_prev_q   <= 1'b1;
      ca_q        <= '0;
      cnt_q       <= '0;
      lat_q       <= '0;
      is_read_q   <= 1'b0;
      is_reg_q    <= 1'b0;
      addr_q      <= '0;
      cr0_q       <= CR0_INIT;
      dq_out_q    <= '0;
      dq_oe_l_q   <= 1'b1;
      rwds_out_q  <= 1'b0;
      rwds_oe_l_q <= 1'b1;
    end else begin
      sync1_q   <= {dram_ck, dram_cs_l, dram_rst_l, dram_rwds_in, dram_dq_in};
      sync2_q   <= sync1_q;
      ck_prev_q <= ck_s;
      cs_prev_q <= cs_s;
      if (!rst_s) begin
        state_q     <= ST_IDLE;
        cr0_q       <= CR0_INIT;
        dq_oe_l_q   <= 1'b1;
        rwds_oe_l_q <= 1'b1;
      end else if (state_q != ST_IDLE && cs_s) begin
        state_q     <= ST_IDLE;
        dq_oe_l_q   <= 1'b1;
        rwds_oe_l_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: if (!cs_s && cs_prev_q) begin
            state_q     <= ST_CA;
            cnt_q       <= '0;
            rwds_oe_l_q <= 1'b0;
            rwds_out_q  <= 1'b1;
          end
          ST_CA: if (ck_edge) begin
            ca_q <= ca_next[39:0];
            if (cnt_q == CA_LAST) begin
              is_read_q   <= dec.is_read;
              is_reg_q    <= dec.is_reg;
              addr_q      <= ADDR_W'(dec.word_addr);
              rwds_oe_l_q <= 1'b1;
              cnt_q       <= '0;
              lat_q       <= '0;
              state_q     <= (!dec.is_read && dec.is_reg) ? ST_REGW : ST_LAT;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
          // Leave on the falling edge after the last latency rising edge so
          // the data phase always begins with an upper-byte rising edge.
          ST_LAT: begin
            if (ck_rise && lat_q != LAT_EDGES)
              lat_q <= lat_q + 8'd1;
            else if (ck_fall && lat_q == LAT_EDGES)
              state_q <= is_read_q ? ST_RDATA : ST_WDATA;
          end
          ST_WDATA: if (ck_fall) addr_q <= addr_q + 1'b1;
          ST_RDATA: begin
            if (ck_rise) begin
              dq_out_q    <= rd_word[15:8];
              dq_oe_l_q   <= 1'b0;
              rwds_out_q  <= 1'b1;
              rwds_oe_l_q <= 1'b0;
            end else if (ck_fall) begin
              dq_out_q    <= rd_word[7:0];
              dq_oe_l_q   <= 1'b0;
              rwds_out_q  <= 1'b0;
              rwds_oe_l_q <= 1'b0;
              addr_q      <= addr_q + 1'b1;
            end
          end
          ST_REGW: if (ck_edge && cnt_q < 3'd2) begin
            if (cnt_q == 3'd0) cr0_q[15:8] <= dq_s;
            else               cr0_q[7:0]  <= dq_s;
            cnt_q <= cnt_q + 3'd1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign dram_dq_out    = dq_out_q;
  assign dram_dq_oe_l   = dq_oe_l_q;
  assign dram_rwds_out  = rwds_out_q;
  assign dram_rwds_oe_l = rwds_oe_l_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hyper_target.sv
// Bench for hyper_target: drives HyperBus transactions from the host side and
// checks results against a word-array/CR0 reference model.
module tb_hyper_target;

  logic       clk = 1'b0, reset = 1'b1;
  logic       dram_ck = 1'b0, dram_cs_l = 1'b1, dram_rst_l = 1'b1, dram_rwds_in = 1'b0;
  logic [7:0] dram_dq_in = 8'h00;
  logic [7:0] dram_dq_out;
  logic       dram_dq_oe_l, dram_rwds_out, dram_rwds_oe_l, busy;

  always #5 clk = ~clk;

  hyper_target #(.ADDR_W(10), .LATENCY(6), .CR0_INIT(16'h8F1F)) dut (
    .clk(clk), .reset(reset), .dram_ck(dram_ck), .dram_cs_l(dram_cs_l),
    .dram_rst_l(dram_rst_l), .dram_dq_in(dram_dq_in), .dram_dq_out(dram_dq_out),
    .dram_dq_oe_l(dram_dq_oe_l), .dram_rwds_in(dram_rwds_in),
    .dram_rwds_out(dram_rwds_out), .dram_rwds_oe_l(dram_rwds_oe_l), .busy(busy)
  );

  int n_checks = 0, n_pass = 0;

  logic [15:0] ref_mem   [1024];
  logic [1:0]  ref_known [1024];
  logic [15:0] ref_cr0;

  logic [7:0]  s_dq;
  logic        s_dq_oe_l, s_rwds, s_rwds_oe_l;
  logic [15:0] wr_data [16];
  logic [1:0]  wr_mask [16];
  logic [15:0] rd_data [16];
  logic [1:0]  rd_rwds [16];
  logic        rd_oe_bad, lat_quiet, ca_rwds_ok, ca_rel_ok, e_dq_oe_l, e_rwds_oe_l;
  int          busy_cyc;

  function automatic logic [47:0] make_ca(input logic rd, input logic rg,
                                          input logic [9:0] a, input logic [47:0] junk);
    logic [47:0] ca;
    ca        = junk;
    ca[47]    = rd;
    ca[46]    = rg;
    ca[45]    = 1'b1;
    ca[22:16] = a[9:3];
    ca[2:0]   = a[2:0];
    return ca;
  endfunction

  task automatic model_write(input int a, input int n);
    for (int i = 0; i < n; i++) begin
      int w = (a + i) % 1024;
      if (!wr_mask[i][1]) begin ref_mem[w][15:8] = wr_data[i][15:8]; ref_known[w][1] = 1'b1; end
      if (!wr_mask[i][0]) begin ref_mem[w][7:0]  = wr_data[i][7:0];  ref_known[w][0] = 1'b1; end
    end
  endtask

  task automatic half(input logic [7:0] b, input logic rw);
    dram_dq_in   = b;
    dram_rwds_in = rw;
    #20 dram_ck = ~dram_ck;
    #34;
    s_dq = dram_dq_out; s_dq_oe_l = dram_dq_oe_l;
    s_rwds = dram_rwds_out; s_rwds_oe_l = dram_rwds_oe_l;
    #6;
  endtask

  task automatic start_xfer();
    dram_cs_l = 1'b0;
    #40;
  endtask

  task automatic send_ca(input logic [47:0] ca);
    ca_rwds_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      half(ca[47-8*i -: 8], 1'b0);
      if (i < 5 && !(s_rwds_oe_l === 1'b0 && s_rwds === 1'b1)) ca_rwds_ok = 1'b0;
    end
    ca_rel_ok = (s_rwds_oe_l === 1'b1);
  endtask

  task automatic lat_phase(input int halves);
    lat_quiet = 1'b1;
    for (int i = 0; i < halves; i++) begin
      half(8'h00, 1'b1);
      if (s_dq_oe_l !== 1'b1 || s_rwds_oe_l !== 1'b1) lat_quiet = 1'b0;
    end
  endtask

  task automatic end_xfer();
    #20 dram_cs_l = 1'b1;
    busy_cyc = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) begin busy_cyc = i; break; end
    end
    @(negedge clk);
    e_dq_oe_l = dram_dq_oe_l; e_rwds_oe_l = dram_rwds_oe_l;
    if (dram_ck) #20 dram_ck = 1'b0;
    #40;
  endtask

  task automatic write_burst(input logic [47:0] ca, input int n);
    start_xfer();
    send_ca(ca);
    if (!(ca[47] == 1'b0 && ca[46] == 1'b1)) lat_phase(24);
    for (int i = 0; i < n; i++) begin
      half(wr_data[i][15:8], wr_mask[i][1]);
      half(wr_data[i][7:0],  wr_mask[i][0]);
    end
    end_xfer();
  endtask

  task automatic read_burst(input logic [47:0] ca, input int n);
    start_xfer();
    send_ca(ca);
    lat_phase(24);
    rd_oe_bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      half(8'h00, 1'b0);
      rd_data[i][15:8] = s_dq; rd_rwds[i][1] = s_rwds;
      if (s_dq_oe_l !== 1'b0 || s_rwds_oe_l !== 1'b0) rd_oe_bad = 1'b1;
      half(8'h00, 1'b0);
      rd_data[i][7:0] = s_dq; rd_rwds[i][0] = s_rwds;
      if (s_dq_oe_l !== 1'b0 || s_rwds_oe_l !== 1'b0) rd_oe_bad = 1'b1;
    end
    end_xfer();
  endtask

  task automatic test_reset();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_checks++; if (dram_dq_oe_l !== 1'b1) $display("FAIL reset_dq_oe_l: got %b expected 1", dram_dq_oe_l); else n_pass++;
    n_checks++; if (dram_rwds_oe_l !== 1'b1) $display("FAIL reset_rwds_oe_l: got %b expected 1", dram_rwds_oe_l); else n_pass++;
    n_checks++; if (dram_dq_out !== 8'h00) $display("FAIL reset_dq_out: got %h expected 00", dram_dq_out); else n_pass++;
    n_checks++; if (dram_rwds_out !== 1'b0) $display("FAIL reset_rwds_out: got %b expected 0", dram_rwds_out); else n_pass++;
  endtask

  task automatic test_write_basic();
    wr_data[0] = 16'hBEEF; wr_mask[0] = 2'b00;
    write_burst(48'h0000_0000_0005, 1);
    model_write(5, 1);
    n_checks++; if (ca_rwds_ok !== 1'b1) $display("FAIL ca_rwds_drive: got %b expected 1", ca_rwds_ok); else n_pass++;
    n_checks++; if (ca_rel_ok !== 1'b1) $display("FAIL ca_rwds_release: got %b expected 1", ca_rel_ok); else n_pass++;
    n_checks++; if (busy_cyc > 3) $display("FAIL write_busy_fall: got %0d cycles expected <=3", busy_cyc); else n_pass++;
  endtask

  task automatic test_read_latency();
    read_burst(48'h8000_0000_0005, 1);
    n_checks++; if (lat_quiet !== 1'b1) $display("FAIL lat_quiet: got %b expected 1", lat_quiet); else n_pass++;
    n_checks++; if (rd_oe_bad !== 1'b0) $display("FAIL read_oe: got %b expected 0", rd_oe_bad); else n_pass++;
    n_checks++; if (rd_data[0] !== 16'hBEEF) $display("FAIL read_beef: got %h expected beef", rd_data[0]); else n_pass++;
    n_checks++; if (rd_rwds[0] !== 2'b10) $display("FAIL read_rwds: got %b expected 10", rd_rwds[0]); else n_pass++;
    n_checks++; if (e_dq_oe_l !== 1'b1 || e_rwds_oe_l !== 1'b1)
      $display("FAIL read_release: got %b%b expected 11", e_dq_oe_l, e_rwds_oe_l); else n_pass++;
  endtask

  task automatic test_masked_write();
    wr_data[0] = 16'h1234; wr_mask[0] = 2'b01;
    write_burst(make_ca(1'b0, 1'b0, 10'd5, '0), 1);
    model_write(5, 1);
    read_burst(make_ca(1'b1, 1'b0, 10'd5, '0), 1);
    n_checks++; if (rd_data[0] !== ref_mem[5]) $display("FAIL masked_write: got %h expected %h", rd_data[0], ref_mem[5]); else n_pass++;
  endtask

  task automatic test_wrap();
    wr_data[0] = 16'hAAAA; wr_mask[0] = 2'b00;
    wr_data[1] = 16'h5555; wr_mask[1] = 2'b00;
    write_burst(make_ca(1'b0, 1'b0, 10'h3FF, '0), 2);
    model_write(10'h3FF, 2);
    read_burst(make_ca(1'b1, 1'b0, 10'h3FF, '0), 2);
    n_checks++; if (rd_data[0] !== 16'hAAAA) $display("FAIL wrap_top: got %h expected aaaa", rd_data[0]); else n_pass++;
    n_checks++; if (rd_data[1] !== 16'h5555) $display("FAIL wrap_next: got %h expected 5555", rd_data[1]); else n_pass++;
    read_burst(make_ca(1'b1, 1'b0, 10'h000, '0), 1);
    n_checks++; if (rd_data[0] !== 16'h5555) $display("FAIL wrap_word0: got %h expected 5555", rd_data[0]); else n_pass++;
  endtask

  task automatic test_regs();
    wr_data[0] = 16'h8F17; wr_mask[0] = 2'b00;
    wr_data[1] = 16'h1234; wr_mask[1] = 2'b00;
    write_burst(48'h6000_0000_0000, 2);
    ref_cr0 = 16'h8F17;
    read_burst(48'hE000_0000_0000, 2);
    n_checks++; if (rd_data[0] !== ref_cr0) $display("FAIL cr0_write: got %h expected %h", rd_data[0], ref_cr0); else n_pass++;
    n_checks++; if (rd_data[1] !== ref_cr0) $display("FAIL cr0_any_addr: got %h expected %h", rd_data[1], ref_cr0); else n_pass++;
    dram_rst_l = 1'b0;
    #100 dram_rst_l = 1'b1;
    #40;
    ref_cr0 = 16'h8F1F;
    read_burst(make_ca(1'b1, 1'b1, 10'h2A5, 48'h1234_5678_9ABC), 1);
    n_checks++; if (rd_data[0] !== ref_cr0) $display("FAIL cr0_rst: got %h expected %h", rd_data[0], ref_cr0); else n_pass++;
    read_burst(make_ca(1'b1, 1'b0, 10'd5, '0), 1);
    n_checks++; if (rd_data[0] !== ref_mem[5]) $display("FAIL rst_keeps_mem: got %h expected %h", rd_data[0], ref_mem[5]); else n_pass++;
  endtask

  task automatic test_abort();
    start_xfer();
    send_ca(make_ca(1'b1, 1'b0, 10'h3FF, '0));
    lat_phase(10);
    end_xfer();
    n_checks++; if (busy_cyc > 3) $display("FAIL abort_lat_busy: got %0d cycles expected <=3", busy_cyc); else n_pass++;
    n_checks++; if (e_dq_oe_l !== 1'b1 || e_rwds_oe_l !== 1'b1)
      $display("FAIL abort_lat_release: got %b%b expected 11", e_dq_oe_l, e_rwds_oe_l); else n_pass++;
    read_burst(make_ca(1'b1, 1'b0, 10'h3FF, '0), 1);
    n_checks++; if (rd_data[0] !== ref_mem[10'h3FF]) $display("FAIL read_after_abort: got %h expected %h", rd_data[0], ref_mem[10'h3FF]); else n_pass++;
    start_xfer();
    send_ca(make_ca(1'b1, 1'b0, 10'h3FF, '0));
    lat_phase(24);
    half(8'h00, 1'b0);
    end_xfer();
    n_checks++; if (e_dq_oe_l !== 1'b1 || e_rwds_oe_l !== 1'b1)
      $display("FAIL abort_data_release: got %b%b expected 11", e_dq_oe_l, e_rwds_oe_l); else n_pass++;
    wr_data[0] = 16'h0F0F; wr_mask[0] = 2'b00;
    write_burst(make_ca(1'b0, 1'b0, 10'd7, '0), 1);
    model_write(7, 1);
    start_xfer();
    send_ca(make_ca(1'b0, 1'b0, 10'd7, '0));
    lat_phase(24);
    half(8'hC3, 1'b0);
    end_xfer();
    wr_data[0] = 16'hC300; wr_mask[0] = 2'b01;
    model_write(7, 1);
    read_burst(make_ca(1'b1, 1'b0, 10'd7, '0), 1);
    n_checks++; if (rd_data[0] !== ref_mem[7]) $display("FAIL partial_write: got %h expected %h", rd_data[0], ref_mem[7]); else n_pass++;
  endtask

  task automatic test_random();
    int          rb_addr [10];
    int          rb_n    [10];
    logic [47:0] junk;
    for (int k = 0; k < 10; k++) begin
      rb_addr[k] = (k % 3 == 0) ? int'($urandom_range(1020, 1023)) : int'($urandom_range(0, 1023));
      rb_n[k]    = int'($urandom_range(1, 4));
      for (int i = 0; i < rb_n[k]; i++) begin
        wr_data[i] = 16'($urandom);
        wr_mask[i] = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      end
      junk = {16'($urandom), $urandom};
      write_burst(make_ca(1'b0, 1'b0, 10'(rb_addr[k]), junk), rb_n[k]);
      model_write(rb_addr[k], rb_n[k]);
    end
    for (int k = 0; k < 10; k++) begin
      junk = {16'($urandom), $urandom};
      read_burst(make_ca(1'b1, 1'b0, 10'(rb_addr[k]), junk), rb_n[k]);
      n_checks++; if (rd_oe_bad !== 1'b0) $display("FAIL rand_oe[%0d]: got %b expected 0", k, rd_oe_bad); else n_pass++;
      for (int i = 0; i < rb_n[k]; i++) begin
        int          w = (rb_addr[k] + i) % 1024;
        logic [15:0] km = {{8{ref_known[w][1]}}, {8{ref_known[w][0]}}};
        n_checks++; if (rd_rwds[i] !== 2'b10) $display("FAIL rand_rwds[%0d.%0d]: got %b expected 10", k, i, rd_rwds[i]); else n_pass++;
        if (km != 16'h0000) begin
          n_checks++;
          if ((rd_data[i] & km) !== (ref_mem[w] & km))
            $display("FAIL rand_data[%03h]: got %h expected %h (mask %h)", w, rd_data[i], ref_mem[w], km);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin ref_mem[i] = '0; ref_known[i] = '0; end
    ref_cr0 = 16'h8F1F;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    test_reset();
    test_write_basic();
    test_read_latency();
    test_masked_write();
    test_wrap();
    test_regs();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
